debugcap: RTL and testbench
===========================

Name: debugcap

Overview:
- Parametrised successor to the two-lane DisplayPort TX debug capture memory.
- Records the per-lane 16-bit symbol pairs and K-flags driven into the transmitter.
- Adds pre/post-trigger ring capture, an internal K-symbol trigger, N-lane width and a status word.
- Sits beside the TX lane mux and is read by the host over the existing debugaddr/debugreq/debugack/debugrdata bus, all in one clock domain.

Parameters:
- NLANES, 2, number of 16-bit lane words per sample; must be 2 or 4. W = NLANES/2 32-bit read words per sample.
- NSZ, 12, log2 of capture depth in samples; SIZE = 1<<NSZ. NSZ + log2(W) must be <= 13.

Ports:
- clk  in  1  sole clock (capture and readout).
- rstn  in  1  asynchronous, active-low reset.
- arm  in  1  one-cycle pulse: clear fill, enter ARMED.
- trigger  in  1  external trigger, level-sampled.
- trigmode  in  1  0 = external trigger; 1 = K-symbol match.
- trigsym  in  8  K-symbol value matched when trigmode=1.
- posttrig  in  NSZ+1  samples stored after trigger, including the trigger sample.
- valid  in  1  sample qualifier.
- txdat  in  16*NLANES  lane words; lane i occupies bits [16i+15:16i].
- txisk  in  2*NLANES  K-flags; bit 2i+j flags byte j of lane i.
- debugaddr  in  16  byte address.
- debugreq  in  1  level request; a rising edge starts one read.
- debugack  out  1  one-cycle read-complete pulse.
- debugrdata  out  32  read data, valid while debugack=1 and held afterwards.
- capstate  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- capfill  out  NSZ+1  number of valid stored samples.

Behaviour:
- Reset values: state IDLE, debugack 0, debugrdata 0, capfill 0, write pointer 0, post counter 0. Memory contents are not reset.
- A sample "qualifies" when valid=1 and state is ARMED or POST.
- On a qualifying sample:
  - mem[wptr] <= txdat; isk[wptr] <= txisk; wptr <= wptr+1, wrapping modulo SIZE.
  - capfill increments and saturates at SIZE.
- Trigger hit:
  - trigmode=0: trigger=1.
  - trigmode=1: any byte with its txisk bit set equals trigsym.
  - A hit counts only on a qualifying cycle.
- State machine:
  - IDLE --arm--> ARMED.
  - ARMED --hit--> POST. The trigger sample is stored; post counter = 1; trigidx <= wptr.
  - POST: post counter increments per qualifying sample. Enter DONE on the edge storing sample number max(posttrig,1), with posttrig clamped to SIZE.
  - posttrig <= 1 goes directly ARMED --> DONE on the hit cycle.
  - DONE holds until arm or reset.
- arm in any state (including mid-POST) restarts: fill 0, post counter 0, state ARMED. wptr is not moved. arm has priority over a same-cycle hit; that cycle's sample is stored as pre-trigger.
- Hits in POST or DONE are ignored.
- Oldest pointer: base = (capfill==SIZE) ? wptr : wptr - capfill, modulo SIZE.
- Read address space, all reads relative to the oldest sample:
  - debugaddr[15]=0, data: sample s = debugaddr[14:2] / W, word k = debugaddr[14:2] % W. Returns lanes 2k+1:2k of mem[(base+s) mod SIZE], arranged {lane 2k+1, lane 2k}.
  - debugaddr[15:14]=10, K-flags: sample s = debugaddr[13:2]. Returns K-flags of sample s zero-extended to 32 bits.
  - debugaddr[15:14]=11, status: {capstate[1:0], 2'b0, trigidx relative to base (NSZ+1 bits, zero-padded to 14), capfill zero-padded to 14}.
  - Samples with s >= capfill return stale memory; this is not an error.
- Read handshake:
  - Rising edge of debugreq is seen on clk edge E. The address is captured at E.
  - The memory read is registered at E+1; debugrdata and debugack=1 at E+2; debugack=0 at E+3.
  - A new rising edge during an outstanding read is ignored.
  - debugreq held high issues exactly one read.
- Reads during ARMED/POST are permitted. Data coherence with a same-cycle write to the same slot is unspecified.
- Reset asserted mid-capture or mid-read: immediate IDLE, debugack 0, no pending ack after release.

Decomposition:
- Shared package dport.vh gains:
  - capture state encodings CAP_IDLE/ARMED/POST/DONE;
  - address-region decode constants DBG_DATA=1'b0, DBG_ISK=2'b10, DBG_STAT=2'b11.
- One sub-module: debugcap_ram, a simple dual-port RAM of width 18*NLANES with registered read.
- FSM, pointers and read path stay in debugcap.

Test Plan:
- NLANES=2, NSZ=4. arm, trigmode=0, posttrig=4, 20 valid samples with txdat=n and trigger at n=10 -> DONE after n=13; capfill=16. Read word 0 returns sample n=-2 (counter value 0xFFFE) … word 15 returns n=13. Status trigidx=12.
- trigmode=1, trigsym=0xBC. Byte 0xBC without K-flag -> no trigger. Same byte with K-flag on lane 3 (NLANES=4) -> POST. Data read at 0x0, 0x4 return lanes 1:0 then 3:2.
- posttrig=0 -> DONE on the hit cycle, capfill includes the hit sample. posttrig=31 with SIZE=16 -> DONE after 16 post samples.
- arm pulsed mid-POST -> ARMED, capfill 0. Trigger asserted in the same cycle as arm is ignored.
- Read handshake: debugreq held high 10 cycles -> exactly one debugack, at E+2. A second rise 1 cycle later is ignored. K-flag read at 0x8004 returns 0x0000000F for sample 1 with all K-flags set.
- rstn dropped in POST and during an outstanding read -> capstate=0, debugack never pulses, debugrdata=0.

Source files
------------

// File: rtl/debugcap_pkg.sv
// Shared definitions for the TX debug capture block: capture state
// encodings, read-address region codes and the status word layout.
package debugcap_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_ARMED = 2'd1,
        CAP_POST  = 2'd2,
        CAP_DONE  = 2'd3
    } cap_state_t;

    // Region decode on the top address bits.
    localparam logic       DBG_DATA = 1'b0;
    localparam logic [1:0] DBG_ISK  = 2'b10;
    localparam logic [1:0] DBG_STAT = 2'b11;

    // Status word: {state, 2'b0, trigger index from oldest, fill}.
    function automatic logic [31:0] status_word(input logic [1:0]  st,
                                                input logic [13:0] trig_rel,
                                                input logic [13:0] fill);
        return {st, 2'b00, trig_rel, fill};
    endfunction

endpackage

// File: rtl/debugcap_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
module debugcap_ram #(
    parameter int DW = 36,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1 << AW];

    // Write on demand, register the read every cycle.
    // NOTE: no reset here so the array maps onto block RAM; the fill count
    // is what tells the host which entries are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/debugcap.sv
// TX lane debug capture: ring buffer of per-lane symbol words and K-flags
// with pre/post-trigger capture, K-symbol trigger and a host read port.
module debugcap
    import debugcap_pkg::*;
#(
    parameter int NLANES = 2,
    parameter int NSZ    = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic                  trigmode,
    input  logic [7:0]            trigsym,
    input  logic [NSZ:0]          posttrig,
    input  logic                  valid,
    input  logic [16*NLANES-1:0]  txdat,
    input  logic [2*NLANES-1:0]   txisk,
    input  logic [15:0]           debugaddr,
    input  logic                  debugreq,
    output logic                  debugack,
    output logic [31:0]           debugrdata,
    output logic [1:0]            capstate,
    output logic [NSZ:0]          capfill
);

    localparam int W  = NLANES / 2;
    localparam int WB = (W == 2) ? 1 : 0;
    localparam int DW = 18 * NLANES;
    localparam logic [NSZ:0] SIZE_V = {1'b1, {NSZ{1'b0}}};
    localparam logic [NSZ:0] ONE_V  = {{NSZ{1'b0}}, 1'b1};

    cap_state_t     state_q, state_d;
    logic [NSZ-1:0] wptr_q, trigidx_q, base, raddr, trig_rel;
    logic [NSZ:0]   fill_q, postcnt_q, postcnt_inc, post_target;
    logic           qual, kmatch, hit;

    logic           req_q, rd_p1, rd_p2, rd_start;
    logic [15:2]    addr_q;
    logic [NSZ-1:0] data_s, isk_s;
    logic [31:0]    stat_q, data_word, isk_word;
    logic [63:0]    dat_ext;
    logic [DW-1:0]  ram_rdata;

    assign qual        = valid && (state_q == CAP_ARMED || state_q == CAP_POST);
    assign hit         = qual && (trigmode ? kmatch : trigger);
    assign postcnt_inc = postcnt_q + 1'b1;
    assign capstate    = state_q;
    assign capfill     = fill_q;

    // K-symbol match: any K-flagged byte equal to the trigger symbol.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch can never be inferred.
        kmatch = 1'b0;
        for (int b = 0; b < 2 * NLANES; b++) begin
            if (txisk[b] && txdat[8*b +: 8] == trigsym) begin
                kmatch = 1'b1;
            end
        end
    end

    // Effective post-trigger length: at least the trigger sample, at most the ring.
    always_comb begin
        if (posttrig > SIZE_V) begin
            post_target = SIZE_V;
        end else if (posttrig == '0) begin
            post_target = ONE_V;
        end else begin
            post_target = posttrig;
        end
    end

    // Capture FSM next state; arm wins over everything, including a hit.
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = CAP_ARMED;
        end else begin
            case (state_q)
                CAP_ARMED: if (hit) state_d = (post_target == ONE_V) ? CAP_DONE : CAP_POST;
                CAP_POST:  if (qual && postcnt_inc == post_target) state_d = CAP_DONE;
                default:   ;
            endcase
        end
    end

    // Capture state, ring pointer, fill and post-trigger bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= CAP_IDLE;
            wptr_q    <= '0;
            trigidx_q <= '0;
            fill_q    <= '0;
            postcnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (qual) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (arm) begin
                // A same-cycle qualifying sample is kept as the first pre-trigger sample.
                fill_q    <= {{NSZ{1'b0}}, qual};
                postcnt_q <= '0;
            end else begin
                if (qual && fill_q != SIZE_V) begin
                    fill_q <= fill_q + 1'b1;
                end
                if (state_q == CAP_ARMED && hit) begin
                    postcnt_q <= ONE_V;
                    trigidx_q <= wptr_q;
                end else if (state_q == CAP_POST && qual) begin
                    postcnt_q <= postcnt_inc;
                end
            end
        end
    end

    debugcap_ram #(.DW(DW), .AW(NSZ)) u_ram (
        .clk   (clk),
        .we    (qual),
        .waddr (wptr_q),
        .wdata ({txisk, txdat}),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    // Read addressing is relative to the oldest valid sample in the ring.
    assign base     = (fill_q == SIZE_V) ? wptr_q : wptr_q - fill_q[NSZ-1:0];
    assign trig_rel = trigidx_q - base;
    assign data_s   = addr_q[2+WB +: NSZ];
    assign isk_s    = NSZ'({1'b0, addr_q[13:2]});
    assign raddr    = base + ((addr_q[15] == DBG_DATA) ? data_s : isk_s);
    assign rd_start = debugreq && !req_q && !rd_p1 && !rd_p2;

    assign dat_ext   = 64'(ram_rdata[16*NLANES-1:0]);
    assign data_word = (W == 2 && addr_q[2]) ? dat_ext[63:32] : dat_ext[31:0];
    assign isk_word  = 32'(ram_rdata[DW-1:16*NLANES]);

    // Host read pipeline: capture at E, RAM/status at E+1, data and ack at E+2.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q      <= 1'b0;
            rd_p1      <= 1'b0;
            rd_p2      <= 1'b0;
            addr_q     <= '0;
            stat_q     <= '0;
            debugack   <= 1'b0;
            debugrdata <= '0;
        end else begin
            req_q    <= debugreq;
            rd_p1    <= rd_start;
            rd_p2    <= rd_p1;
            debugack <= rd_p2;
            if (rd_start) begin
                addr_q <= debugaddr[15:2];
            end
            if (rd_p1) begin
                stat_q <= status_word(state_q, 14'(trig_rel), 14'(fill_q));
            end
            if (rd_p2) begin
                if (addr_q[15] == DBG_DATA) begin
                    debugrdata <= data_word;
                end else if (addr_q[15:14] == DBG_ISK) begin
                    debugrdata <= isk_word;
                end else begin
                    debugrdata <= stat_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_debugcap.sv
// Directed bench for debugcap: a 2-lane and a 4-lane instance (16 samples
// each) share stimulus; expected values are worked out by hand.
module tb_debugcap;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        arm = 1'b0;
    logic        trigger = 1'b0;
    logic        trigmode = 1'b0;
    logic [7:0]  trigsym = '0;
    logic [4:0]  posttrig = '0;
    logic        valid = 1'b0;
    logic [63:0] txdat = '0;
    logic [7:0]  txisk = '0;
    logic [15:0] debugaddr = '0;
    logic        debugreq = 1'b0;

    logic        ack_a, ack_b;
    logic [31:0] rd_a, rd_b;
    logic [1:0]  st_a, st_b;
    logic [4:0]  fill_a, fill_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    debugcap #(.NLANES(2), .NSZ(4)) u_a (
        .clk(clk), .rstn(rstn), .arm(arm), .trigger(trigger), .trigmode(trigmode),
        .trigsym(trigsym), .posttrig(posttrig), .valid(valid),
        .txdat(txdat[31:0]), .txisk(txisk[3:0]),
        .debugaddr(debugaddr), .debugreq(debugreq), .debugack(ack_a),
        .debugrdata(rd_a), .capstate(st_a), .capfill(fill_a)
    );

    debugcap #(.NLANES(4), .NSZ(4)) u_b (
        .clk(clk), .rstn(rstn), .arm(arm), .trigger(trigger), .trigmode(trigmode),
        .trigsym(trigsym), .posttrig(posttrig), .valid(valid),
        .txdat(txdat), .txisk(txisk),
        .debugaddr(debugaddr), .debugreq(debugreq), .debugack(ack_b),
        .debugrdata(rd_b), .capstate(st_b), .capfill(fill_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic smp(input logic [63:0] dat, input logic [7:0] isk, input logic trg);
        valid   = 1'b1;
        txdat   = dat;
        txisk   = isk;
        trigger = trg;
        @(negedge clk);
        valid   = 1'b0;
        trigger = 1'b0;
        txisk   = '0;
    endtask

    task automatic rd(input logic [15:0] addr, output logic [31:0] da, output logic [31:0] db);
        bit got = 0;
        da = '0;
        db = '0;
        debugaddr = addr;
        debugreq  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack_a) begin
                da  = rd_a;
                db  = rd_b;
                got = 1;
                break;
            end
        end
        if (!got) check("rd_timeout", 32'd0, 32'd1);
        debugreq = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] va, vb;
        int acks, first;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state", 32'(st_a), 32'd0);
        check("rst_fill", 32'(fill_a), 32'd0);
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_rdata", rd_a, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Samples in IDLE are not stored
        smp(64'h1, 8'h0, 1'b1);
        check("idle_fill", 32'(fill_a), 32'd0);
        check("idle_state", 32'(st_a), 32'd0);

        // External trigger, posttrig=4, samples n=-6..13, trigger at n=10
        trigmode = 1'b0;
        posttrig = 5'd4;
        pulse_arm();
        check("armed", 32'(st_a), 32'd1);
        for (int n = -6; n <= 13; n++) begin
            smp({48'h0, 16'(n)}, 8'h0, n == 10);
            if (n == 12) check("post_n12", 32'(st_a), 32'd2);
        end
        check("done_n13", 32'(st_a), 32'd3);
        check("fill16", 32'(fill_a), 32'd16);
        smp(64'h5555, 8'h0, 1'b1);
        smp(64'h6666, 8'h0, 1'b1);
        check("done_hold", 32'(st_a), 32'd3);
        check("done_fill", 32'(fill_a), 32'd16);
        rd(16'h0000, va, vb);
        check("rd_w0", va, 32'h0000FFFE);
        rd(16'h0030, va, vb);
        check("rd_w12", va, 32'h0000000A);
        rd(16'h003C, va, vb);
        check("rd_w15", va, 32'h0000000D);
        rd(16'hC000, va, vb);
        check("stat_a", va, 32'hC0030010);
        check("stat_b", vb, 32'hC0030010);

        // K-symbol trigger on BC
        trigmode = 1'b1;
        trigsym  = 8'hBC;
        posttrig = 5'd8;
        pulse_arm();
        smp(64'h4444_3333_2222_11BC, 8'h00, 1'b0);
        check("k_noflag", 32'(st_b), 32'd1);
        smp(64'hBC00_7777_6666_5555, 8'h80, 1'b0);
        check("k_lane3_b", 32'(st_b), 32'd2);
        check("k_lane3_a", 32'(st_a), 32'd1);
        rd(16'h0000, va, vb);
        check("k_rd0_b", vb, 32'h2222_11BC);
        rd(16'h0004, va, vb);
        check("k_rd4_b", vb, 32'h4444_3333);
        check("k_rd4_a", va, 32'h6666_5555);

        // posttrig=0: done on the hit cycle
        trigmode = 1'b0;
        posttrig = 5'd0;
        pulse_arm();
        smp(64'h1, 8'h0, 1'b0);
        smp(64'h2, 8'h0, 1'b0);
        smp(64'h3, 8'h0, 1'b0);
        smp(64'h4, 8'h0, 1'b1);
        check("pt0_state", 32'(st_a), 32'd3);
        check("pt0_fill", 32'(fill_a), 32'd4);

        // posttrig=31 clamps to 16 post samples
        posttrig = 5'd31;
        pulse_arm();
        smp(64'h1, 8'h0, 1'b0);
        smp(64'h2, 8'h0, 1'b0);
        smp(64'h3, 8'h0, 1'b1);
        for (int i = 0; i < 14; i++) smp(64'(i), 8'h0, 1'b0);
        check("pt31_15", 32'(st_a), 32'd2);
        smp(64'h9, 8'h0, 1'b0);
        check("pt31_16", 32'(st_a), 32'd3);
        check("pt31_fill", 32'(fill_a), 32'd16);

        // arm mid-POST, then arm with a same-cycle trigger
        posttrig = 5'd8;
        pulse_arm();
        smp(64'h1, 8'h0, 1'b1);
        smp(64'h2, 8'h0, 1'b0);
        smp(64'h3, 8'h0, 1'b0);
        check("mid_post", 32'(st_a), 32'd2);
        check("mid_fill", 32'(fill_a), 32'd3);
        pulse_arm();
        check("rearm_state", 32'(st_a), 32'd1);
        check("rearm_fill", 32'(fill_a), 32'd0);
        arm = 1'b1; valid = 1'b1; trigger = 1'b1; txdat = 64'h7;
        @(negedge clk);
        arm = 1'b0; valid = 1'b0; trigger = 1'b0;
        check("arm_beats_hit", 32'(st_a), 32'd1);
        smp(64'h8, 8'h0, 1'b0);
        check("still_armed", 32'(st_a), 32'd1);

        // Read handshake: held request, latency, K-flag readback
        pulse_arm();
        smp(64'h0, 8'h00, 1'b0);
        smp(64'h0, 8'h0F, 1'b0);
        smp(64'h0, 8'h00, 1'b0);
        debugaddr = 16'h8004;
        debugreq  = 1'b1;
        acks = 0; first = -1; va = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack_a) begin
                acks++;
                if (first < 0) first = i;
                va = rd_a;
            end
        end
        debugreq = 1'b0;
        @(negedge clk);
        check("held_acks", 32'(acks), 32'd1);
        check("ack_latency", 32'(first), 32'd3);
        check("kflag_rd", va, 32'h0000000F);
        acks = 0;
        debugreq = 1'b1;
        @(negedge clk);
        if (ack_a) acks++;
        debugreq = 1'b0;
        @(negedge clk);
        if (ack_a) acks++;
        debugreq = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ack_a) acks++;
        end
        debugreq = 1'b0;
        @(negedge clk);
        check("rerise_acks", 32'(acks), 32'd1);

        // Reset during POST with a read outstanding
        pulse_arm();
        smp(64'h1, 8'h0, 1'b1);
        check("pre_rst_post", 32'(st_a), 32'd2);
        debugaddr = 16'h0000;
        debugreq  = 1'b1;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_state", 32'(st_a), 32'd0);
        check("rst_mid_ack", 32'(ack_a), 32'd0);
        check("rst_mid_rdata", rd_a, 32'd0);
        debugreq = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_a) acks++;
        end
        check("rst_no_ack", 32'(acks), 32'd0);
        check("rst_rdata_hold", rd_a, 32'd0);
        check("rst_fill", 32'(fill_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
